// File: rtl/luma_pkg.sv
// Shared types and constants for the 3x3 luma window stage.
package luma_pkg;
   localparam int COLORDEPTH = 8;
   localparam int LAT        = 2;

   typedef logic [COLORDEPTH-1:0] pixel_t;
   typedef pixel_t [8:0]          window_t;

   // Window tap positions, row-major from the oldest line.
   localparam int TL = 0;
   localparam int TC = 1;
   localparam int TR = 2;
   localparam int ML = 3;
   localparam int C  = 4;
   localparam int MR = 5;
   localparam int BL = 6;
   localparam int BC = 7;
   localparam int BR = 8;
endpackage

// File: rtl/luma_win3x3_line_ram.sv
// Simple dual-port line buffer: synchronous read, read returns old data on a same-address write.
module line_ram #(
   parameter int DEPTH = 1024,
   parameter int W     = luma_pkg::COLORDEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/luma_win3x3.sv
// 3x3 luma neighbourhood generator: two line buffers, column/line counters,
// window shift registers and a matching delay on the video timing signals.
module luma_win3x3 #(
   parameter int MAX_WIDTH  = 1024,
   parameter int COLORDEPTH = luma_pkg::COLORDEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [COLORDEPTH-1:0]   gamma_i,
   input  logic                    dv_i,
   input  logic                    hs_i,
   input  logic                    vs_i,
   output logic [9*COLORDEPTH-1:0] win_o,
   output logic                    win_valid_o,
   output logic                    dv_o,
   output logic                    hs_o,
   output logic                    vs_o,
   output logic                    ovf_o
);
   import luma_pkg::*;

   localparam int XW = $clog2(MAX_WIDTH);

   logic [XW-1:0]                 x, x1;
   logic                          x_full;
   logic [1:0]                    y;
   logic                          dv_d, vs_d, line_armed;
   logic [COLORDEPTH-1:0]         pix1, rd0, rd1;
   logic                          p1_v, p1_win;
   logic [8:0][COLORDEPTH-1:0]    win;
   logic [LAT-1:0]                dv_dl, hs_dl, vs_dl;
   logic                          pix_ok, dv_fall, vs_rise;

   assign pix_ok  = dv_i & ~x_full;
   assign dv_fall = dv_d & ~dv_i;
   assign vs_rise = vs_i & ~vs_d;

   // lb1 takes the previous line one cycle late, once lb0's old word has been read out.
   line_ram #(.DEPTH(MAX_WIDTH), .W(COLORDEPTH)) u_lb0 (
      .clk(clk), .we(pix_ok), .waddr(x), .wdata(gamma_i), .raddr(x), .rdata(rd0)
   );
   line_ram #(.DEPTH(MAX_WIDTH), .W(COLORDEPTH)) u_lb1 (
      .clk(clk), .we(p1_v), .waddr(x1), .wdata(rd0), .raddr(x), .rdata(rd1)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x           <= '0;
         x1          <= '0;
         x_full      <= 1'b0;
         y           <= '0;
         // dv_d starts high so a line already in progress at release is not counted as complete.
         dv_d        <= 1'b1;
         vs_d        <= 1'b0;
         line_armed  <= 1'b0;
         pix1        <= '0;
         p1_v        <= 1'b0;
         p1_win      <= 1'b0;
         win         <= '0;
         win_valid_o <= 1'b0;
         ovf_o       <= 1'b0;
         dv_dl       <= '0;
         hs_dl       <= '0;
         vs_dl       <= '0;
      end else begin
         dv_d   <= dv_i;
         vs_d   <= vs_i;
         pix1   <= gamma_i;
         x1     <= x;
         p1_v   <= pix_ok;
         p1_win <= pix_ok && (y == 2'd2) && (x >= XW'(2));
         if (dv_i && !dv_d) line_armed <= 1'b1;

         if (vs_rise) begin
            x      <= '0;
            x_full <= 1'b0;
            y      <= '0;
            ovf_o  <= 1'b0;
         end else if (dv_fall) begin
            x          <= '0;
            x_full     <= 1'b0;
            line_armed <= 1'b0;
            if (line_armed && y != 2'd2) y <= y + 2'd1;
         end else if (dv_i) begin
            if (x_full)                          ovf_o  <= 1'b1;
            else if (x == XW'(MAX_WIDTH - 1))    x_full <= 1'b1;
            else                                 x      <= x + XW'(1);
         end

         if (p1_v) begin
            for (int r = 0; r < 3; r++) begin
               win[3*r]   <= win[3*r+1];
               win[3*r+1] <= win[3*r+2];
            end
            win[TR] <= rd1;
            win[MR] <= rd0;
            win[BR] <= pix1;
         end
         win_valid_o <= p1_win;

         dv_dl <= {dv_dl[LAT-2:0], dv_i};
         hs_dl <= {hs_dl[LAT-2:0], hs_i};
         vs_dl <= {vs_dl[LAT-2:0], vs_i};
      end
   end

   assign win_o = win;
   assign dv_o  = dv_dl[LAT-1];
   assign hs_o  = hs_dl[LAT-1];
   assign vs_o  = vs_dl[LAT-1];
endmodule

// File: doc/luma_win3x3.md
Name: luma_win3x3

Overview:
- Downstream consumer of the RGB-to-luma stage. Takes the 8-bit luma stream with its dv/hs/vs timing.
- Buffers the two previous video lines and emits a 3x3 luma neighbourhood window for every pixel whose full window lies inside the frame.
- Feeds the spatial filter and edge-detect stages that follow.
- Output timing signals are delayed to stay aligned with the window.

Parameters:
- MAX_WIDTH, 1024, maximum active pixels per line; sets line-RAM depth.
- COLORDEPTH, 8, luma bits per pixel.
- XW, $clog2(MAX_WIDTH), column counter width (derived; not overridden).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset; asynchronous, active-low.
- gamma_i  in  COLORDEPTH  luma pixel, valid when dv_i=1.
- dv_i  in  1  data valid; high during the active part of a line.
- hs_i  in  1  horizontal sync, passed through.
- vs_i  in  1  vertical sync; its rising edge starts a new frame.
- win_o  out  9*COLORDEPTH  window, row-major. [7:0]=top-left (x-2,y-2), [71:64]=bottom-right (x,y), where (x,y) is the newest pixel.
- win_valid_o  out  1  win_o holds a complete window.
- dv_o  out  1  dv_i delayed by LAT.
- hs_o  out  1  hs_i delayed by LAT.
- vs_o  out  1  vs_i delayed by LAT.
- ovf_o  out  1  sticky: a line exceeded MAX_WIDTH in this frame.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0: win_o, win_valid_o, dv_o, hs_o, vs_o, ovf_o.
  - Column counter x, line counter y and window registers cleared.
  - Line-RAM contents undefined; no output depends on them until y>=2.
- Latency LAT=2 cycles from a dv_i pixel to the win_o and win_valid_o that use it.
  - Cycle 1: synchronous RAM read at address x, and the input pixel is registered.
  - Cycle 2: the 3 column taps shift into the window registers.
  - dv_o, hs_o and vs_o pass through a matching 2-stage delay.
- Column counter x:
  - Increments on each cycle with dv_i=1.
  - Cleared on the cycle after a dv_i falling edge (end of line).
- Line counter y:
  - Increments on a dv_i falling edge and saturates at 2 (2 bits).
  - A vs_i rising edge clears x, y and ovf_o.
  - If the vs_i rising edge and a dv_i falling edge occur in the same cycle, vs wins and y=0.
- Line RAMs lb0 (line y-1) and lb1 (line y-2), each MAX_WIDTH x COLORDEPTH. For each valid pixel at column x:
  - Read lb0[x] and lb1[x].
  - Write lb0[x]<=gamma_i and lb1[x]<=old lb0[x].
  - Read-before-write on the same address: the read returns the old data.
- Window:
  - Each valid pixel shifts the window left by one column.
  - The new right column is {lb1[x], lb0[x], gamma_i}, top to bottom.
  - Window registers hold their value when dv is low.
- win_valid_o = 1 exactly LAT cycles after a dv_i=1 cycle that had y>=2 and x>=2. Otherwise 0.
  - It is never asserted for the first two lines or the first two columns.
  - Windows never straddle two lines, because x restarts each line.
- Overflow:
  - If dv_i=1 when x=MAX_WIDTH-1 has already been consumed, x saturates, RAM writes are suppressed and win_valid_o is forced to 0 for that pixel.
  - ovf_o sets on that cycle and holds until the next vs_i rising edge.
- Reset mid-frame: after rst is released, no win_valid_o until two complete lines have been seen again.
- Lines of different lengths: each column uses whatever data was stored at that address. This is not an error, and ovf_o is not set.

Decomposition:
- Package luma_pkg: COLORDEPTH; typedef pixel_t (logic [COLORDEPTH-1:0]); typedef window_t (pixel_t [8:0]); constant LAT=2; window index constants (TL=0 ... BR=8; centre C=4).
- Sub-module line_ram: single-clock simple dual-port RAM (1 read, 1 write, synchronous read, read-before-write), instantiated twice.
- Counters, window registers and delay lines stay in the top level.

Test Plan:
- Reset: hold rst=0 for 5 cycles with random inputs driven -> all outputs 0. Release -> win_valid_o stays 0 for the whole first two lines.
- Ramp frame, 8x4, pixel=16*y+x, back-to-back lines with 4 blanking cycles -> first win_valid_o 2 cycles after pixel (2,2). win_o = {0x22,0x21,0x20,0x12,0x11,0x10,0x02,0x01,0x00} (MSB first). 6 valid windows per line on lines 2 and 3 (12 in total).
- Latency and alignment: single-cycle hs_i and vs_i pulses -> hs_o and vs_o are identical pulses exactly 2 cycles later. dv_o matches the dv_i pattern shifted by 2.
- New frame: vs_i rising edge after 3 lines, then a new ramp -> no win_valid_o on new lines 0 and 1. Windows on line 2 contain only new-frame values.
- Overflow: MAX_WIDTH=16, drive an 18-pixel line -> ovf_o=1 from the cycle the 17th pixel is presented. No window uses pixels 17 or 18. Next vs_i rising edge -> ovf_o=0.
- Async reset mid-line 3 (rst low for 1 cycle, between clock edges) -> outputs clear immediately without waiting for a clock edge. Recovery behaves as in the reset scenario.
